// File: rtl/ysyx_22050019_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave memory arbiter.
// LSU has priority, and a streak counter keeps a waiting IFU from starving.
module ysyx_22050019_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_req_addr,
  output logic                s_req_wen,
  output logic [DATA_W-1:0]   s_req_wdata,
  output logic [DATA_W/8-1:0] s_req_wstrb,
  input  logic                s_resp_valid,
  output logic                s_resp_ready,
  input  logic [DATA_W-1:0]   s_resp_rdata,
  output logic [1:0]          owner_o
);

  localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_next;
  logic [1:0]          owner, owner_next;
  logic [STREAK_W-1:0] streak, streak_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= OWN_NONE;
      streak <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      streak <= streak_next;
    end
  end

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    streak_next    = streak;
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    s_req_valid    = 1'b0;
    s_req_addr     = '0;
    s_req_wen      = 1'b0;
    s_req_wdata    = '0;
    s_req_wstrb    = '0;
    s_resp_ready   = 1'b0;

    case (state)
      IDLE: begin
        // Streak counts LSU wins only while the IFU is actually waiting.
        if (lsu_req_valid && !(ifu_req_valid && streak == STREAK_MAX)) begin
          owner_next  = OWN_LSU;
          state_next  = REQ;
          if (ifu_req_valid)
            streak_next = (streak == STREAK_MAX) ? streak : streak + 1'b1;
          else
            streak_next = '0;
        end else if (ifu_req_valid) begin
          owner_next  = OWN_IFU;
          state_next  = REQ;
          streak_next = '0;
        end
      end
      REQ: begin
        if (owner == OWN_IFU) begin
          s_req_valid   = ifu_req_valid;
          s_req_addr    = ifu_req_addr;
          ifu_req_ready = s_req_ready;
        end else if (owner == OWN_LSU) begin
          s_req_valid   = lsu_req_valid;
          s_req_addr    = lsu_req_addr;
          s_req_wen     = lsu_req_wen;
          s_req_wdata   = lsu_req_wdata;
          s_req_wstrb   = lsu_req_wstrb;
          lsu_req_ready = s_req_ready;
        end
        if (s_req_valid && s_req_ready)
          state_next = RESP;
      end
      RESP: begin
        if (owner == OWN_IFU) begin
          ifu_resp_valid = s_resp_valid;
          ifu_resp_rdata = s_resp_rdata;
          s_resp_ready   = ifu_resp_ready;
        end else if (owner == OWN_LSU) begin
          lsu_resp_valid = s_resp_valid;
          lsu_resp_rdata = s_resp_rdata;
          s_resp_ready   = lsu_resp_ready;
        end
        if (s_resp_valid && s_resp_ready) begin
          owner_next = OWN_NONE;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  assign owner_o = owner;

endmodule
